// File: rtl/gs_cfg_pager.sv
// gs_cfg_pager: ACEX1K configuration sequencer, warm-reset pulse generator and Z80 page-register memory map.
// Latency: FPGA status pins 2-cycle synchronised plus 1 FSM cycle; port writes act next cycle; io_rdata/memory map combinational.
// Backpressure: none; Z80 I/O strobes are single-cycle and always accepted.
//
// Ports:
//   clkin, coldres                      - clock, asynchronous active-high cold reset
//   io_wr, io_rd, io_addr, io_wdata     - Z80 I/O strobes (pre-synchronised), port select {a7,a6}, write data
//   io_rdata                            - read data (port 1 = memcfg, port 2 = config status)
//   a15, a14                            - Z80 upper address bits
//   status_n, conf_done, init_done      - FPGA config status pins (asynchronous)
//   config_n                            - FPGA nCONFIG
//   fpga_cs, disbl                      - FPGA chip select; FPGA owns memory when disbl=1
//   mema, romcs_n, ramcs_n              - paged memory address bits [14+PAGE_W:14] and chip selects
//   warmres_n, cfg_err                  - warm reset (active low); sticky configuration error
//
// Build option: define GS_CFG_TIMEOUT_EN to add the wait-state timeout counter (timeout -> ERROR).

module gs_cfg_pager #(
  parameter int PAGE_W      = 4,
  parameter int CFG_LOW_CYC = 64,
  parameter int TIMEOUT_W   = 20,
  parameter int RST_CYC     = 16
) (
  input  logic            clkin,
  input  logic            coldres,
  input  logic            io_wr,
  input  logic            io_rd,
  input  logic [1:0]      io_addr,
  input  logic [7:0]      io_wdata,
  output logic [7:0]      io_rdata,
  input  logic            a15,
  input  logic            a14,
  input  logic            status_n,
  input  logic            conf_done,
  input  logic            init_done,
  output logic            config_n,
  output logic            fpga_cs,
  output logic            disbl,
  output logic [PAGE_W:0] mema,
  output logic            romcs_n,
  output logic            ramcs_n,
  output logic            warmres_n,
  output logic            cfg_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG_LOW   = 3'd1,
    WAIT_ST   = 3'd2,
    LOADING   = 3'd3,
    WAIT_INIT = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  typedef struct packed {
    logic              ram_sel;
    logic [PAGE_W-1:0] page;
  } memcfg_t;

  localparam int LOW_W = $clog2(CFG_LOW_CYC);
  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [LOW_W-1:0] LOW_INIT = LOW_W'(CFG_LOW_CYC - 1);
  localparam logic [RST_W-1:0] RST_INIT = RST_W'(RST_CYC - 1);

  state_t           state, state_next;
  memcfg_t          memcfg;
  logic [LOW_W-1:0] low_cnt;
  logic [RST_W-1:0] rst_cnt;
  logic [2:0]       sync1, sync2;
  logic             status_n_s, conf_done_s, init_done_s;
  logic             was_cold_n;
  logic             wr_p1, wr_p2, cfg_start, tmo_hit, done_entry;
  logic             unused_wdata;

  assign unused_wdata = ^io_wdata;

  // Two-flop synchronisers for the asynchronous FPGA status pins.
  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {status_n, conf_done, init_done};
      sync2 <= sync1;
    end
  end

  assign status_n_s  = sync2[2];
  assign conf_done_s = sync2[1];
  assign init_done_s = sync2[0];

  assign wr_p1 = io_wr && (io_addr == 2'd1);
  assign wr_p2 = io_wr && (io_addr == 2'd2);

`ifdef GS_CFG_TIMEOUT_EN
  // The increment that would land on all-ones is the timeout, so a waiting
  // state lasts at most 2^TIMEOUT_W-1 cycles. Any state change clears it.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] tmo_cnt;

  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) begin
      tmo_cnt <= '0;
    end else if (state_next != state) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_ST || state == LOADING || state == WAIT_INIT) begin
      tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) state <= CFG_LOW;
    else         state <= state_next;
  end

  // FSM next state and outputs
  always_comb begin
    state_next = state;
    config_n   = 1'b1;
    cfg_start  = 1'b0;
    case (state)
      IDLE: ;
      CFG_LOW: begin
        config_n = 1'b0;
        if (low_cnt == '0) state_next = WAIT_ST;
      end
      WAIT_ST: begin
        if (status_n_s)   state_next = LOADING;
        else if (tmo_hit) state_next = ERROR;
      end
      LOADING: begin
        if (!status_n_s)      state_next = ERROR;
        else if (conf_done_s) state_next = WAIT_INIT;
        else if (tmo_hit)     state_next = ERROR;
      end
      WAIT_INIT: begin
        if (!status_n_s)      state_next = ERROR;
        else if (init_done_s) state_next = DONE;
        else if (tmo_hit)     state_next = ERROR;
      end
      DONE:  ;
      ERROR: ;
      default: state_next = IDLE;
    endcase
    // A restart request is honoured only when no configuration is in flight.
    if (wr_p2 && !io_wdata[0] && (state == IDLE || state == DONE || state == ERROR)) begin
      cfg_start  = 1'b1;
      state_next = CFG_LOW;
    end
  end

  assign done_entry = (state_next == DONE) && (state != DONE);

  // nCONFIG low-time counter
  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) begin
      low_cnt <= LOW_INIT;
    end else if (cfg_start) begin
      low_cnt <= LOW_INIT;
    end else if (state == CFG_LOW && low_cnt != '0) begin
      low_cnt <= low_cnt - LOW_W'(1);
    end
  end

  // Control/status registers
  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) begin
      disbl      <= 1'b0;
      cfg_err    <= 1'b0;
      was_cold_n <= 1'b0;
      memcfg     <= '0;
    end else begin
      if (cfg_start) begin
        disbl   <= 1'b0;
        cfg_err <= 1'b0;
      end else begin
        if (state == DONE)       disbl   <= 1'b1;
        if (state_next == ERROR) cfg_err <= 1'b1;
      end
      if (wr_p2 && io_wdata[7]) was_cold_n <= 1'b1;
      if (wr_p1) begin
        memcfg.ram_sel <= io_wdata[7];
        memcfg.page    <= io_wdata[PAGE_W-1:0];
      end
    end
  end

  // Warm reset: low while counting down, plus the cycle at zero -> RST_CYC low cycles.
  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) begin
      rst_cnt   <= RST_INIT;
      warmres_n <= 1'b0;
    end else if (done_entry) begin
      rst_cnt   <= RST_INIT;
      warmres_n <= 1'b0;
    end else if (rst_cnt != '0) begin
      rst_cnt   <= rst_cnt - RST_W'(1);
    end else begin
      warmres_n <= 1'b1;
    end
  end

  // Memory map; board drivers are tristated when the FPGA owns memory.
  always_comb begin
    mema    = '0;
    romcs_n = 1'b1;
    ramcs_n = 1'b1;
    if (!disbl) begin
      if (!a15) begin
        if (a14) ramcs_n = 1'b0;
        else     romcs_n = 1'b0;
      end else begin
        mema = {memcfg.page, a14};
        if (memcfg.ram_sel) ramcs_n = 1'b0;
        else                romcs_n = 1'b0;
      end
    end
  end

  assign fpga_cs = (io_addr == 2'd3);

  always_comb begin
    io_rdata = '0;
    if (io_rd) begin
      case (io_addr)
        2'd1:    io_rdata = {memcfg.ram_sel, 7'(memcfg.page)};
        2'd2:    io_rdata = {status_n_s, conf_done_s, init_done_s, was_cold_n, cfg_err, state};
        default: io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_cfg_pager.sv
module tb_gs_cfg_pager;

  localparam int PAGE_W = 4;

  logic            clkin = 1'b0;
  logic            coldres;
  logic            io_wr, io_rd;
  logic [1:0]      io_addr;
  logic [7:0]      io_wdata;
  logic [7:0]      io_rdata;
  logic            a15, a14;
  logic            status_n, conf_done, init_done;
  logic            config_n, fpga_cs, disbl;
  logic [PAGE_W:0] mema;
  logic            romcs_n, ramcs_n, warmres_n, cfg_err;

  gs_cfg_pager #(
    .PAGE_W(PAGE_W), .CFG_LOW_CYC(64), .TIMEOUT_W(6), .RST_CYC(16)
  ) dut (
    .clkin(clkin), .coldres(coldres),
    .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .a15(a15), .a14(a14),
    .status_n(status_n), .conf_done(conf_done), .init_done(init_done),
    .config_n(config_n), .fpga_cs(fpga_cs), .disbl(disbl), .mema(mema),
    .romcs_n(romcs_n), .ramcs_n(ramcs_n), .warmres_n(warmres_n), .cfg_err(cfg_err)
  );

  always #5 clkin = ~clkin;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] wr;
    logic       a15;
    logic       a14;
    logic [4:0] mema;
    logic       romcs_n;
    logic       ramcs_n;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_addr  = a;
    io_wdata = d;
    io_wr    = 1'b1;
    cyc();
    io_wr    = 1'b0;
    io_addr  = 2'd0;
    io_wdata = 8'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    io_rd   = 1'b1;
    io_addr = a;
    #1;
    d       = io_rdata;
    io_rd   = 1'b0;
    io_addr = 2'd0;
  endtask

  task automatic chk_state(input string name, input logic [2:0] st);
    logic [7:0] dd;
    rd(2'd2, dd);
    chk(name, dd[2:0], st);
  endtask

  task automatic wait_state(input logic [2:0] st, input int max, input string name);
    logic [7:0] dd;
    logic       ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      rd(2'd2, dd);
      if (dd[2:0] == st) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n, first_w;

    vecs[0] = '{8'h85, 1'b1, 1'b1, 5'b01011, 1'b1, 1'b0, 8'h85};
    vecs[1] = '{8'h85, 1'b1, 1'b0, 5'b01010, 1'b1, 1'b0, 8'h85};
    vecs[2] = '{8'h85, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 8'h85};
    vecs[3] = '{8'h85, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 8'h85};
    vecs[4] = '{8'h05, 1'b1, 1'b1, 5'b01011, 1'b0, 1'b1, 8'h05};
    vecs[5] = '{8'h0F, 1'b1, 1'b0, 5'b11110, 1'b0, 1'b1, 8'h0F};
    vecs[6] = '{8'hFA, 1'b1, 1'b1, 5'b10101, 1'b1, 1'b0, 8'h8A};
    vecs[7] = '{8'h70, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b1, 8'h00};
    vecs[8] = '{8'h83, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 8'h83};

    coldres = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_addr = 2'd0; io_wdata = 8'd0;
    a15 = 1'b0; a14 = 1'b0; status_n = 1'b1; conf_done = 1'b0; init_done = 1'b0;
    cyc(); cyc();

    // Reset state
    chk("rst_config_n", config_n, 1'b0);
    chk("rst_disbl", disbl, 1'b0);
    chk("rst_warmres_n", warmres_n, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_romcs_n", romcs_n, 1'b0);
    rd(2'd2, d); chk("rst_port2", d, 8'h01);
    rd(2'd1, d); chk("rst_port1", d, 8'h00);

    // Power-on configuration: nCONFIG low time and power-on warm reset
    coldres = 1'b0;
    n = 0; first_w = -1;
    for (int k = 0; k < 200; k++) begin
      if (warmres_n && first_w < 0) first_w = k;
      if (config_n) break;
      n++;
      cyc();
    end
    chk("cfg_low_cycles", n, 64);
    chk("warmres_after_reset", first_w, 16);
    chk_state("state_wait_st", 3'd2);
    cyc();
    rd(2'd2, d); chk("port2_loading", d, 8'h83);
    conf_done = 1'b1;
    cyc(); cyc();
    chk_state("conf_done_sync_lag", 3'd3);
    cyc();
    chk_state("state_wait_init", 3'd4);
    init_done = 1'b1;
    cyc(); cyc();
    chk_state("init_done_sync_lag", 3'd4);
    cyc();
    chk_state("state_done", 3'd5);
    chk("disbl_at_done_entry", disbl, 1'b0);
    chk("warmres_at_done_entry", warmres_n, 1'b0);
    cyc();
    chk("disbl_4cyc", disbl, 1'b1);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      if (warmres_n) break;
      n++;
      cyc();
    end
    chk("warmres_done_cycles", n, 16);
    chk("disbl_romcs_n", romcs_n, 1'b1);
    chk("disbl_ramcs_n", ramcs_n, 1'b1);
    a15 = 1'b1; a14 = 1'b1; #1;
    chk("disbl_mema", mema, 5'd0);
    a15 = 1'b0; a14 = 1'b0;

    // Port 2 writes in DONE: bit0=1 has no FSM effect, 0x80 restarts and sets was_cold_n
    wr(2'd2, 8'h01);
    rd(2'd2, d); chk("wr01_in_done", d, 8'hE5);
    conf_done = 1'b0; init_done = 1'b0;
    wr(2'd2, 8'h80);
    rd(2'd2, d); chk("restart_status", d[4:0], 5'b10001);
    chk("restart_disbl", disbl, 1'b0);
    n = config_n ? 0 : 1;
    wr(2'd2, 8'h00);
    for (int i = 0; i < 200; i++) begin
      if (config_n) break;
      n++;
      cyc();
    end
    chk("restart_low_cycles", n, 64);

    // Restart ignored in LOADING; status_n drop -> ERROR
    cyc();
    chk_state("reload_loading", 3'd3);
    wr(2'd2, 8'h00);
    chk_state("start_ignored_loading", 3'd3);
    status_n = 1'b0;
    cyc(); cyc();
    chk_state("status_sync_lag", 3'd3);
    cyc();
    rd(2'd2, d); chk("port2_error", d, 8'h1E);
    chk("error_cfg_err", cfg_err, 1'b1);
    chk("error_disbl", disbl, 1'b0);
    chk("error_config_n", config_n, 1'b1);
    status_n = 1'b1;

    // Memory map and port 1 readback table
    for (int i = 0; i < 9; i++) begin
      wr(2'd1, vecs[i].wr);
      a15 = vecs[i].a15; a14 = vecs[i].a14;
      #1;
      chk($sformatf("vec%0d_mema", i), mema, vecs[i].mema);
      chk($sformatf("vec%0d_romcs_n", i), romcs_n, vecs[i].romcs_n);
      chk($sformatf("vec%0d_ramcs_n", i), ramcs_n, vecs[i].ramcs_n);
      rd(2'd1, d);
      chk($sformatf("vec%0d_port1", i), d, vecs[i].rd);
    end
    for (int a = 0; a < 4; a++) begin
      io_addr = 2'(a); io_rd = 1'b1; #1;
      chk($sformatf("fpga_cs_addr%0d", a), fpga_cs, (a == 3) ? 1'b1 : 1'b0);
      if (a == 0 || a == 3) chk($sformatf("rdata_zero_addr%0d", a), io_rdata, 8'h00);
    end
    io_rd = 1'b0; io_addr = 2'd1; #1;
    chk("rdata_zero_no_rd", io_rdata, 8'h00);
    io_addr = 2'd0; a15 = 1'b0; a14 = 1'b0;

    // Restart from ERROR, reach WAIT_INIT, then cold reset mid-operation
    wr(2'd2, 8'h00);
    chk("restart_clears_err", cfg_err, 1'b0);
    chk_state("restart_from_error", 3'd1);
    wr(2'd1, 8'h8C);
    wr(2'd2, 8'h80);
    wait_state(3'd3, 200, "reach_loading");
    conf_done = 1'b1;
    wait_state(3'd4, 10, "reach_wait_init");
    coldres = 1'b1;
    #1;
    chk("cold_config_n", config_n, 1'b0);
    chk("cold_warmres_n", warmres_n, 1'b0);
    chk("cold_disbl", disbl, 1'b0);
    rd(2'd1, d); chk("cold_port1", d, 8'h00);
    rd(2'd2, d); chk("cold_port2", d, 8'h01);
    a15 = 1'b1; a14 = 1'b1; #1;
    chk("cold_mema", mema, 5'b00001);
    chk("cold_romcs_n", romcs_n, 1'b0);
    a15 = 1'b0; a14 = 1'b0; conf_done = 1'b0;
    cyc();
    coldres = 1'b0;

    // Timeout while LOADING with conf_done never asserted
    wait_state(3'd3, 200, "tmo_reach_loading");
`ifdef GS_CFG_TIMEOUT_EN
    repeat (62) cyc();
    chk_state("tmo_before_limit", 3'd3);
    cyc();
    chk_state("tmo_error", 3'd6);
    chk("tmo_cfg_err", cfg_err, 1'b1);
`else
    repeat (1000) cyc();
    chk_state("no_tmo_still_loading", 3'd3);
    chk("no_tmo_cfg_err", cfg_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
